// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Segment codes are active-high in {g,f,e,d,c,b,a} order; output polarity
// is applied only at the pin registers of the top module.
package seg_pkg;

  localparam logic [6:0] SEG_CODE_0 = 7'h3F;
  localparam logic [6:0] SEG_CODE_1 = 7'h06;
  localparam logic [6:0] SEG_CODE_2 = 7'h5B;
  localparam logic [6:0] SEG_CODE_3 = 7'h4F;
  localparam logic [6:0] SEG_CODE_4 = 7'h66;
  localparam logic [6:0] SEG_CODE_5 = 7'h6D;
  localparam logic [6:0] SEG_CODE_6 = 7'h7D;
  localparam logic [6:0] SEG_CODE_7 = 7'h07;
  localparam logic [6:0] SEG_CODE_8 = 7'h7F;
  localparam logic [6:0] SEG_CODE_9 = 7'h6F;
  localparam logic [6:0] SEG_CODE_A = 7'h77;
  localparam logic [6:0] SEG_CODE_B = 7'h7C;
  localparam logic [6:0] SEG_CODE_C = 7'h39;
  localparam logic [6:0] SEG_CODE_D = 7'h5E;
  localparam logic [6:0] SEG_CODE_E = 7'h79;
  localparam logic [6:0] SEG_CODE_F = 7'h71;

  // All segments dark, active-high sense.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Ceiling log2 for elaboration-time width calculations (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-high 7-segment code. Codes 10..15 light only when
// hex_en is set; otherwise they render as a dark digit.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] code
);

  // Combinational lookup of the segment pattern for one digit.
  always_comb begin
    code = SEG_OFF;
    case (nibble)
      4'h0:    code = SEG_CODE_0;
      4'h1:    code = SEG_CODE_1;
      4'h2:    code = SEG_CODE_2;
      4'h3:    code = SEG_CODE_3;
      4'h4:    code = SEG_CODE_4;
      4'h5:    code = SEG_CODE_5;
      4'h6:    code = SEG_CODE_6;
      4'h7:    code = SEG_CODE_7;
      4'h8:    code = SEG_CODE_8;
      4'h9:    code = SEG_CODE_9;
      4'hA:    code = hex_en ? SEG_CODE_A : SEG_OFF;
      4'hB:    code = hex_en ? SEG_CODE_B : SEG_OFF;
      4'hC:    code = hex_en ? SEG_CODE_C : SEG_OFF;
      4'hD:    code = hex_en ? SEG_CODE_D : SEG_OFF;
      4'hE:    code = hex_en ? SEG_CODE_E : SEG_OFF;
      4'hF:    code = hex_en ? SEG_CODE_F : SEG_OFF;
      default: code = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_multi.sv
// Parametrised multiplexed 7-segment scan driver. Digit data is loaded into
// shadow registers only at frame boundaries so a frame never shows a mix of
// old and new values. Segment and select pins are both registered from the
// same slot state so they always change together.
module seg_scan_multi
  import seg_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int SCAN_CYC    = 10000,
  parameter int BRIGHT_W    = 4,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_blank_en,
  input  logic                  hex_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  load,
  output logic                  load_ack,
  output logic                  frame_start,
  output logic [7:0]            segment,
  output logic [DIGITS-1:0]     seg_sel
);

  localparam int CNT_W = (clog2(SCAN_CYC) < 1) ? 1 : clog2(SCAN_CYC);
  localparam int IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
  localparam int PWM_W = CNT_W + BRIGHT_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(32'd1);
  localparam logic [PWM_W-1:0] PWM_ONE    = PWM_W'(32'd1);
  localparam logic [PWM_W-1:0] SCAN_CYC_W = PWM_W'(SCAN_CYC);

  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] shadow_data_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [DIGITS-1:0]   shadow_blank_r;
  logic                load_pending_r;

  logic                fb_s;
  logic                capture_s;
  logic [DIGITS-1:0]   lz_vec_s;
  logic                all_zero_s;
  logic [3:0]          nibble_s;
  logic                dp_cur_s;
  logic                blank_cur_s;
  logic                lz_cur_s;
  logic [6:0]          code_s;
  logic [PWM_W-1:0]    pwm_lhs_s;
  logic [PWM_W-1:0]    pwm_rhs_s;
  logic                lit_s;
  logic [7:0]          seg_on_s;
  logic [DIGITS-1:0]   sel_on_s;

  assign fb_s      = (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
  assign capture_s = load_pending_r | load;

  // Slot counter and digit index; index steps on the last cycle of a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Load handshake: requests are held pending and honoured only at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data_r  <= {(4*DIGITS){1'b0}};
      shadow_dp_r    <= {DIGITS{1'b0}};
      shadow_blank_r <= {DIGITS{1'b0}};
      load_pending_r <= 1'b0;
      load_ack       <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= fb_s;
      if (fb_s) begin
        load_ack       <= capture_s;
        load_pending_r <= 1'b0;
        if (capture_s) begin
          shadow_data_r  <= digit_data;
          shadow_dp_r    <= dp_in;
          shadow_blank_r <= blank_mask;
        end
      end else begin
        load_ack <= 1'b0;
        if (load) begin
          load_pending_r <= 1'b1;
        end
      end
    end
  end

  // Leading-zero map: digit i>0 is blank when it and every higher nibble are zero.
  always_comb begin
    all_zero_s = 1'b1;
    lz_vec_s   = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero_s = all_zero_s & (shadow_data_r[i*4 +: 4] == 4'h0);
      if (i > 0) begin
        lz_vec_s[i] = all_zero_s & lz_blank_en;
      end else begin
        lz_vec_s[i] = 1'b0;
      end
    end
  end

  // PWM window: lit while cnt*2^BRIGHT_W < (brightness+1)*SCAN_CYC, full width.
  always_comb begin
    pwm_lhs_s = {{(BRIGHT_W + 1){1'b0}}, cnt_r} << BRIGHT_W;
    pwm_rhs_s = (PWM_W'(brightness) + PWM_ONE) * SCAN_CYC_W;
    lit_s     = (pwm_lhs_s < pwm_rhs_s);
  end

  // Select the current digit's shadow fields and build the one-hot select.
  always_comb begin
    nibble_s    = 4'h0;
    dp_cur_s    = 1'b0;
    blank_cur_s = 1'b0;
    lz_cur_s    = 1'b0;
    sel_on_s    = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      nibble_s    = nibble_s | (shadow_data_r[i*4 +: 4] & {4{idx_r == IDX_W'(i)}});
      dp_cur_s    = dp_cur_s    | (shadow_dp_r[i]    & (idx_r == IDX_W'(i)));
      blank_cur_s = blank_cur_s | (shadow_blank_r[i] & (idx_r == IDX_W'(i)));
      lz_cur_s    = lz_cur_s    | (lz_vec_s[i]       & (idx_r == IDX_W'(i)));
      sel_on_s[i] = lit_s & (idx_r == IDX_W'(i));
    end
  end

  seg_hex_decode u_decode (
    .nibble (nibble_s),
    .hex_en (hex_en),
    .code   (code_s)
  );

  // Active-high segment image: masked digits go fully dark, LZ digits keep their dp.
  always_comb begin
    if (!lit_s) begin
      seg_on_s = 8'h00;
    end else if (blank_cur_s) begin
      seg_on_s = 8'h00;
    end else if (lz_cur_s) begin
      seg_on_s = {dp_cur_s, SEG_OFF};
    end else begin
      seg_on_s = {dp_cur_s, code_s};
    end
  end

  // Pin registers: segment and select share one edge and apply output polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      segment <= {8{SEG_ACT_LOW}};
      seg_sel <= {DIGITS{SEL_ACT_LOW}};
    end else begin
      segment <= seg_on_s ^ {8{SEG_ACT_LOW}};
      seg_sel <= sel_on_s ^ {DIGITS{SEL_ACT_LOW}};
    end
  end

endmodule

// File: doc/seg_scan_multi.md
Name: seg_scan_multi

Overview:
Parametrised multiplexed 7-segment scan driver. It is the successor to the fixed 6-digit decimal scanner.
- Adds: any digit count, hex decode, per-digit decimal point, blank mask, leading-zero blanking, PWM brightness, selectable output polarity, and tear-free frame-synchronous data loading.
- Sits between the clock/counter logic and the board's segment and digit-select pins.

Parameters:
DIGITS, 6, number of digits scanned (1..16)
SCAN_CYC, 10000, clock cycles per digit slot (>=2)
BRIGHT_W, 4, brightness input width
SEG_ACT_LOW, 1, 1 = segment pins active-low
SEL_ACT_LOW, 1, 1 = digit-select pins active-low

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
digit_data  in  4*DIGITS  nibble i = digit i; digit 0 = rightmost = bits[3:0]
dp_in  in  DIGITS  decimal point per digit
blank_mask  in  DIGITS  1 = digit fully dark, including dp
lz_blank_en  in  1  leading-zero blanking enable (sampled live)
hex_en  in  1  1 = decode codes 10..15 as A b C d E F (sampled live)
brightness  in  BRIGHT_W  duty level; all-ones = full on (sampled live)
load  in  1  single-cycle request to snapshot digit_data/dp_in/blank_mask
load_ack  out  1  one-cycle pulse when the snapshot is taken
frame_start  out  1  one-cycle pulse at the start of each scan frame
segment  out  8  {dp,g,f,e,d,c,b,a}
seg_sel  out  DIGITS  one-hot digit select, bit i = digit i

Behaviour:
- Only one clock (clk) and one reset: rst is synchronous and active-high.
- Reset:
  - cnt=0, idx=0, shadow data/dp/blank=0, load_pending=0.
  - load_ack=0, frame_start=0.
  - segment = all off (8'hFF when SEG_ACT_LOW).
  - seg_sel = all inactive (all ones when SEL_ACT_LOW).
  - Reset mid-frame drops any pending load.
- Slot counter cnt runs 0..SCAN_CYC-1 and wraps.
- Digit index idx advances on cnt==SCAN_CYC-1 and wraps DIGITS-1 -> 0.
- Frame boundary (FB) = cnt==SCAN_CYC-1 && idx==DIGITS-1. With DIGITS=1, FB occurs every slot.
- Load handshake:
  - load sets load_pending.
  - At the FB edge, if load_pending or load is high, the shadow registers capture the inputs, load_pending clears, and load_ack is high in the next cycle.
  - A load arriving in the FB cycle itself is captured at that boundary.
  - Repeated loads before FB collapse into one capture of the values present at FB.
- frame_start is high in the cycle where cnt==0 and idx==0 (i.e. after each FB). It coincides with load_ack.
- Decode uses active-high gfedcba, inverted at the output per the polarity parameters:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
  - A=77 b=7C C=39 d=5E E=79 F=71
  - With hex_en=0, codes 10..15 decode to blank (all segments off).
- dp: segment[7] = shadow dp bit of the current digit.
- Leading-zero blanking (lz_blank_en=1):
  - Digit i>0 is blanked when its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - The dp of an LZ-blanked digit still lights if set.
- Blanked digit (mask or LZ): seg_sel stays active for its slot, segments off.
- PWM:
  - A slot is lit while cnt*2^BRIGHT_W < (brightness+1)*SCAN_CYC.
  - Compare width = clog2(SCAN_CYC)+BRIGHT_W+1, no truncation.
  - While unlit: seg_sel all inactive and segment all off.
- Output timing:
  - segment and seg_sel are registered and change on the same edge, one cycle after cnt/idx.
  - No skew between segment and seg_sel.
  - On a slot change, the old digit is never shown with the new select.

Decomposition:
- Shared package seg_pkg holds:
  - the 16 segment code constants,
  - the SEG_OFF constant,
  - a clog2 helper function.
- One combinational sub-module, seg_hex_decode (nibble, hex_en -> 7-bit code).
- Counters, shadow registers, PWM compare and output registers stay in the top module.

Test Plan:
Bench parameters: DIGITS=4, SCAN_CYC=8, BRIGHT_W=2, both polarities active-low.
- Reset: hold rst 3 cycles -> segment=8'hFF, seg_sel=4'b1111. After release, seg_sel steps 1110,1101,1011,0111,1110, 8 cycles each.
- Load: brightness=3, load pulse with digit_data=16'h1234 -> one load_ack at the next FB. Then digit0 slot shows 8'h99 and digit3 slot shows 8'hF9. Data changed without load is not displayed.
- Hex: nibble A with hex_en=0 -> segment 8'hFF in that slot; with hex_en=1 -> 8'h88. dp_in[0]=1 on digit value 0 -> 8'h40.
- LZ blanking: lz_blank_en=1, data=16'h0050 -> digits 3 and 2 show 8'hFF with sel active; digit 1 shows 8'h92; digit 0 shows 8'hC0. Data 16'h0000 -> only digit 0 lit, showing 8'hC0.
- Brightness: brightness=0 -> seg_sel active for cnt 0..1 of each slot (2 cycles), inactive for 6. brightness=3 -> active for all 8.
- Boundary and reset: load asserted exactly in the FB cycle -> captured, load_ack next cycle. load followed by rst before FB -> no capture, no load_ack, shadow stays 0.
